// File: rtl/pico_pkg.sv
// Shared types and instruction-field positions for the pico-MIPS control path.
package pico_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_ADDI = 4'd2,
        OP_SUB  = 4'd3,
        OP_SUBI = 4'd4,
        OP_MULI = 4'd5,
        OP_BEQ  = 4'd6,
        OP_BNE  = 4'd7,
        OP_WAIT = 4'd8,
        OP_HALT = 4'd9
    } opcode_t;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'd0,
        ALU_SUB  = 2'd1,
        ALU_MUL  = 2'd2,
        ALU_PASS = 2'd3
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_RUN          = 2'd0,
        ST_WAIT_PRESS   = 2'd1,
        ST_WAIT_RELEASE = 2'd2,
        ST_HALT         = 2'd3
    } ctrl_state_t;

    localparam int OPC_HI = 19;
    localparam int OPC_LO = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 13;
    localparam int RS_HI  = 12;
    localparam int RS_LO  = 10;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: two-flop synchronizer followed by a stable-level counter.
module btn_debounce #(
    parameter int DbCycles = 4
) (
    input  logic clk,
    input  logic n_reset,
    input  logic btn,
    output logic db
);

    localparam int CntW = (DbCycles > 1) ? $clog2(DbCycles) : 1;

    logic            btn_meta;
    logic            btn_s;
    logic [CntW-1:0] cnt;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
            cnt      <= '0;
            db       <= 1'b0;
        end else begin
            btn_meta <= btn;
            btn_s    <= btn_meta;
            // Any cycle where the synchronized level agrees with db restarts the count.
            if (btn_s == db) begin
                cnt <= '0;
            end else if (cnt == CntW'(DbCycles - 1)) begin
                db  <= ~db;
                cnt <= '0;
            end else begin
                cnt <= cnt + CntW'(1);
            end
        end
    end

endmodule

// File: rtl/ctrl_seq.sv
// Control sequencer: instruction decode, branch/stall control of the PC and
// the wait-for-button / halt state machine.
module ctrl_seq
    import pico_pkg::*;
#(
    parameter int AddrSz   = 6,
    parameter int InstrSz  = 20,
    parameter int DbCycles = 4
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic [InstrSz-1:0] instr,
    input  logic               alu_zero,
    input  logic               btn,
    output logic               rel_branch,
    output logic [AddrSz-1:0]  offset,
    output logic               reg_we,
    output logic [1:0]         alu_op,
    output logic               imm_sel,
    output logic               waiting,
    output logic               halted
);

    ctrl_state_t state;
    ctrl_state_t state_next;
    opcode_t     opcode;
    alu_op_t     alu_sel;
    logic [7:0]  imm;
    logic        db;
    logic        unused_fields;

    assign opcode        = opcode_t'(instr[OPC_HI:OPC_LO]);
    assign imm           = instr[IMM_HI:IMM_LO];
    assign unused_fields = ^{instr[RD_HI:RS_LO], instr[9:8]};

    btn_debounce #(
        .DbCycles(DbCycles)
    ) u_db (
        .clk    (clk),
        .n_reset(n_reset),
        .btn    (btn),
        .db     (db)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rel_branch = 1'b0;
        offset     = '0;
        reg_we     = 1'b0;
        alu_sel    = ALU_ADD;
        imm_sel    = 1'b0;
        unique case (state)
            ST_RUN: begin
                case (opcode)
                    OP_ADD:  reg_we = 1'b1;
                    OP_ADDI: begin reg_we = 1'b1; imm_sel = 1'b1; end
                    OP_SUB:  begin reg_we = 1'b1; alu_sel = ALU_SUB; end
                    OP_SUBI: begin reg_we = 1'b1; alu_sel = ALU_SUB; imm_sel = 1'b1; end
                    OP_MULI: begin reg_we = 1'b1; alu_sel = ALU_MUL; imm_sel = 1'b1; end
                    OP_BEQ, OP_BNE: begin
                        alu_sel = ALU_SUB;
                        if ((opcode == OP_BEQ) == alu_zero) begin
                            rel_branch = 1'b1;
                            offset     = AddrSz'(imm);
                        end
                    end
                    OP_WAIT: begin rel_branch = 1'b1; state_next = ST_WAIT_PRESS; end
                    OP_HALT: begin rel_branch = 1'b1; state_next = ST_HALT; end
                    default: ;
                endcase
            end
            ST_WAIT_PRESS: begin
                rel_branch = 1'b1;
                if (db) state_next = ST_WAIT_RELEASE;
            end
            ST_WAIT_RELEASE: begin
                // Releasing lets the PC step past the WAIT in the same cycle.
                rel_branch = db;
                if (!db) state_next = ST_RUN;
            end
            ST_HALT: rel_branch = 1'b1;
            default: state_next = ST_RUN;
        endcase
    end

    assign alu_op  = alu_sel;
    assign waiting = (state == ST_WAIT_PRESS) || (state == ST_WAIT_RELEASE);
    assign halted  = (state == ST_HALT);

endmodule
